// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------
// mac_pkg : shared types and widths for the MAC sequencer
// Rev 1.0 : initial release
// ---------------------------------------------------------------
`default_nettype none

package mac_pkg;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

`default_nettype wire

// File: rtl/wallace.sv
// ---------------------------------------------------------------
// wallace : combinational 8x8 unsigned carry-save tree multiplier
// Rev 1.0 : initial release
// ---------------------------------------------------------------
`default_nettype none

module wallace
  import mac_pkg::*;
(
  input  logic [OP_W-1:0]   i_a,
  input  logic [OP_W-1:0]   i_b,
  output logic [PROD_W-1:0] o_p
);

  logic [PROD_W-1:0] w_pp [OP_W];

  for (genvar i = 0; i < OP_W; i++) begin : g_pp
    assign w_pp[i] = PROD_W'(i_a & {OP_W{i_b[i]}}) << i;
  end

  // Carries beyond bit 15 only add multiples of 2^16, so truncation is exact.
  function automatic logic [2*PROD_W-1:0] csa(input logic [PROD_W-1:0] x,
                                               input logic [PROD_W-1:0] y,
                                               input logic [PROD_W-1:0] z);
    logic [PROD_W-1:0] s;
    logic [PROD_W-1:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  logic [PROD_W-1:0] w_s1a, w_c1a, w_s1b, w_c1b;
  logic [PROD_W-1:0] w_s2a, w_c2a, w_s2b, w_c2b;
  logic [PROD_W-1:0] w_s3, w_c3, w_s4, w_c4;

  assign {w_c1a, w_s1a} = csa(w_pp[0], w_pp[1], w_pp[2]);
  assign {w_c1b, w_s1b} = csa(w_pp[3], w_pp[4], w_pp[5]);
  assign {w_c2a, w_s2a} = csa(w_s1a, w_c1a, w_s1b);
  assign {w_c2b, w_s2b} = csa(w_c1b, w_pp[6], w_pp[7]);
  assign {w_c3, w_s3}   = csa(w_s2a, w_c2a, w_s2b);
  assign {w_c4, w_s4}   = csa(w_s3, w_c3, w_c2b);

  assign o_p = w_s4 + w_c4;

endmodule

`default_nettype wire

// File: rtl/mac_sequencer.sv
// ---------------------------------------------------------------
// mac_sequencer : dot-product engine time-sharing one 8x8 multiplier
// Rev 1.0 : initial release
// ---------------------------------------------------------------
`default_nettype none

module mac_sequencer
  import mac_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_len_q;
  logic [LEN_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_prod_q;
  logic               r_prod_v;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;

  logic [PROD_W-1:0]  w_prod;
  logic               w_hs;
  logic               w_last;
  logic               w_accept;
  logic [ACC_W:0]     w_sum;

  wallace u_mul (
    .i_a (in_a),
    .i_b (in_b),
    .o_p (w_prod)
  );

  assign w_hs     = in_valid && (r_state == RUN);
  assign w_last   = (r_cnt == (r_len_q - LEN_W'(1)));
  assign w_accept = start && (r_state == IDLE);
  assign w_sum    = {1'b0, r_acc} + {1'b0, r_prod_q};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (len != '0) ? RUN : DONE;
      RUN:     if (w_hs && w_last) w_next = DRAIN;
      DRAIN:   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // The accumulator is only touched when a product is pending; a new job
  // clears it in IDLE, where no product can be pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_q  <= '0;
      r_cnt    <= '0;
      r_prod_q <= '0;
      r_prod_v <= 1'b0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_prod_v <= w_hs;
      if (w_hs) begin
        r_prod_q <= ACC_W'(w_prod);
        r_cnt    <= r_cnt + LEN_W'(1);
      end
      if (w_accept) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
        r_cnt <= '0;
        if (len != '0) r_len_q <= len;
      end else if (r_prod_v) begin
        r_acc <= w_sum[ACC_W-1:0];
        r_ovf <= r_ovf | w_sum[ACC_W];
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign in_ready  = (r_state == RUN);
  assign out_valid = (r_state == DONE);
  assign out_acc   = r_acc;
  assign out_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mac_sequencer.sv
// ---------------------------------------------------------------
// tb_mac_sequencer : job-table bench with result scoreboard, two widths
// Rev 1.0 : initial release
// ---------------------------------------------------------------
`default_nettype none

module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [7:0]  len, in_a, in_b;
  logic        busy, in_ready, out_valid, out_ovf;
  logic [23:0] out_acc;
  logic        busy16, in_ready16, out_valid16, out_ovf16;
  logic [15:0] out_acc16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_sequencer #(.ACC_W(24), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf)
  );

  mac_sequencer #(.ACC_W(16), .LEN_W(8)) dut16 (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy16),
    .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16), .out_ovf(out_ovf16)
  );

  typedef struct {
    int              len;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    int              acc24;
    int              acc16;
    bit              ovf16;
  } vec_t;

  typedef struct {
    int acc24;
    int acc16;
    bit ovf16;
  } exp_t;

  vec_t tbl [7];
  exp_t sbq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic fill(input int i, input int l,
                      input int a0, input int b0, input int a1, input int b1,
                      input int a2, input int b2, input int a3, input int b3,
                      input int e24, input int e16, input bit o16);
    tbl[i].len   = l;
    tbl[i].a     = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    tbl[i].b     = {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    tbl[i].acc24 = e24;
    tbl[i].acc16 = e16;
    tbl[i].ovf16 = o16;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("acc24", 32'(out_acc), 32'(e.acc24));
        chk("ovf24", 32'(out_ovf), 32'd0);
        chk("acc16", 32'(out_acc16), 32'(e.acc16));
        chk("ovf16", 32'(out_ovf16), 32'(e.ovf16));
        chk("valid16", 32'(out_valid16), 32'd1);
      end
    end
  end

  task automatic run_job(input int idx, input logic [15:0] vmask, input bit release_done);
    int k;
    int cyc;
    bit hs;
    exp_t e;
    start = 1'b1;
    len   = 8'(tbl[idx].len);
    e.acc24 = tbl[idx].acc24;
    e.acc16 = tbl[idx].acc16;
    e.ovf16 = tbl[idx].ovf16;
    sbq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    len   = 8'($urandom);
    if (tbl[idx].len == 0) begin
      chk("empty_valid", 32'(out_valid), 32'd1);
      chk("empty_ready", 32'(in_ready), 32'd0);
    end else begin
      k   = 0;
      cyc = 0;
      while (k < tbl[idx].len && cyc < 100) begin
        in_valid = vmask[4'(cyc)];
        in_a     = in_valid ? tbl[idx].a[k] : 8'($urandom);
        in_b     = in_valid ? tbl[idx].b[k] : 8'($urandom);
        hs       = in_valid && in_ready;
        @(posedge clk); #1;
        if (hs) k++;
        cyc++;
      end
      chk("pairs_accepted", 32'(k), 32'(tbl[idx].len));
      in_valid = 1'b0;
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
      chk("drain_valid", 32'(out_valid), 32'd0);
      chk("drain_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("latency_valid", 32'(out_valid), 32'd1);
    end
    if (release_done) begin
      cyc = 0;
      while (busy && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("back_to_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1;

    fill(0, 3, 255, 255, 2, 3, 0, 9, 0, 0,  65031, 65031, 1'b0);
    fill(1, 2, 255, 255, 255, 255, 0, 0, 0, 0, 130050, 64514, 1'b1);
    fill(2, 4, 1, 1, 2, 2, 3, 3, 4, 4,  30, 30, 1'b0);
    fill(3, 1, 16, 16, 0, 0, 0, 0, 0, 0,  256, 256, 1'b0);
    fill(4, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1'b0);
    fill(5, 4, 200, 100, 17, 13, 128, 2, 99, 99,  30278, 30278, 1'b0);
    fill(6, 1, 7, 8, 0, 0, 0, 0, 0, 0,  56, 56, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_acc", 32'(out_acc), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_job(0, 16'hFFFF, 1'b1);
    run_job(4, 16'hFFFF, 1'b1);
    run_job(1, 16'hFFFF, 1'b1);

    // Stalled input stream, then hold the result under backpressure.
    out_ready = 1'b0;
    run_job(2, 16'h0059, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_acc", 32'(out_acc), 32'd30);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      start = 1'b1;
      len   = 8'd5;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("bp_still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", 32'(busy), 32'd0);

    // Reset in the middle of a job.
    start = 1'b1; len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_a = 8'd5; in_b = 8'd6;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_acc", 32'(out_acc), 32'd0);
    chk("mid_rst_acc16", 32'(out_acc16), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_job(6, 16'hFFFF, 1'b1);

    // Back-to-back jobs, start in the cycle after each result handshake.
    run_job(3, 16'hFFFF, 1'b1);
    run_job(5, 16'hFFFF, 1'b1);
    run_job(3, 16'hFFFF, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
